regfile_writeback: RTL and testbench

//   Writeback sequencer that drives the write side of the 32x32 register file.
//   It accepts completed results from execute/memory over a valid/ready handshake
//   and buffers them in a FIFO. It decodes each destination: rd for R-type
//   (instruction_check=0) or rt for I-type (instruction_check=1). It then issues
//   at most one register-file write per clock.
//   It also publishes a busy mask of pending destinations for decode-stage hazard checks.

---
 rtl/regfile_writeback.sv | 199 +++++++++++++++++++
 tb/tb_regfile_writeback.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// -----------------------------------------------------------------------------
// regfile_writeback
//
// Writeback sequencer for the write side of a 32x32 register file.
// Completed results from execute/memory arrive over a valid/ready handshake and
// are buffered in a small FIFO. The destination of each result is decoded when
// the result is pushed. Entries leave the FIFO in order, one per clock, and
// drive a registered write port toward the register file. A combinational busy
// mask of pending destinations feeds decode-stage hazard detection.
//
// Ports
//   clk                   rising-edge clock
//   rst_n                 asynchronous active-low reset
//   in_valid / in_ready   result handshake (in_ready = FIFO not full)
//   in_instruction        instruction that produced the result
//   in_result             result value
//   wb_stall              hold the head entry (no pop this cycle)
//   flush                 synchronous discard of every queued entry
//   wb_write_enable       one-cycle write pulse to the register file
//   wb_instruction_check  0 = address from rd [15:11], 1 = address from rt [20:16]
//   wb_instruction        instruction forwarded as the register file address source
//   wb_data               data forwarded to the register file
//   busy_mask             bit r set while any queued or issuing entry targets r
//   occupancy             number of valid FIFO entries
// -----------------------------------------------------------------------------
module regfile_writeback #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instruction,
    input  logic [31:0]      in_result,
    input  logic             wb_stall,
    input  logic             flush,
    output logic             wb_write_enable,
    output logic             wb_instruction_check,
    output logic [31:0]      wb_instruction,
    output logic [31:0]      wb_data,
    output logic [31:0]      busy_mask,
    output logic [CNT_W-1:0] occupancy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Destination decode: {check, index}. An index of 0 means "no write";
    // register $0 is hardwired so a write to it is suppressed the same way.
    function automatic logic [5:0] decode_dest(input logic [31:0] instr);
        logic [5:0] res;
        res = 6'd0;
        case (instr[31:26])
            6'h00: begin
                // SPECIAL: everything but jr writes rd
                if (instr[5:0] != 6'h08) begin
                    res = {1'b0, instr[15:11]};
                end else begin
                    res = 6'd0;
                end
            end
            6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23: begin
                res = {1'b1, instr[20:16]};
            end
            default: begin
                res = 6'd0;
            end
        endcase
        return res;
    endfunction

    // FIFO storage
    logic [31:0]      instr_mem_r [DEPTH];
    logic [31:0]      data_mem_r  [DEPTH];
    logic [4:0]       dest_mem_r  [DEPTH];
    logic             check_mem_r [DEPTH];

    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;

    // Write-port registers
    logic             wb_we_r;
    logic             wb_check_r;
    logic [31:0]      wb_instr_r;
    logic [31:0]      wb_data_r;
    logic [4:0]       wb_dest_r;

    logic             full_s;
    logic             push_s;
    logic             pop_s;
    logic [5:0]       in_dec_s;
    logic [31:0]      busy_s;

    // Handshake and FIFO control; flush overrides both push and pop
    always_comb begin
        full_s   = (count_r == FULL_CNT);
        push_s   = in_valid & ~full_s & ~flush;
        pop_s    = (count_r != {CNT_W{1'b0}}) & ~wb_stall & ~flush;
        in_dec_s = decode_dest(in_instruction);
    end

    // Entry storage, written at the tail on each accepted push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_r[i] <= 32'h0;
                data_mem_r[i]  <= 32'h0;
                dest_mem_r[i]  <= 5'd0;
                check_mem_r[i] <= 1'b0;
            end
        end else if (push_s) begin
            instr_mem_r[tail_r] <= in_instruction;
            data_mem_r[tail_r]  <= in_result;
            dest_mem_r[tail_r]  <= in_dec_s[4:0];
            check_mem_r[tail_r] <= in_dec_s[5];
        end
    end

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (flush) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                tail_r <= tail_r + PTR_ONE;
            end
            if (pop_s) begin
                head_r <= head_r + PTR_ONE;
            end
            // push is gated by full and pop by empty, so this cannot wrap
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Write port: loaded from the popped head; the enable is a single-cycle pulse
    // and the address/data fields hold their last value between pops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_we_r    <= 1'b0;
            wb_check_r <= 1'b0;
            wb_instr_r <= 32'h0;
            wb_data_r  <= 32'h0;
            wb_dest_r  <= 5'd0;
        end else if (pop_s) begin
            wb_we_r    <= (dest_mem_r[head_r] != 5'd0);
            wb_check_r <= check_mem_r[head_r];
            wb_instr_r <= instr_mem_r[head_r];
            wb_data_r  <= data_mem_r[head_r];
            wb_dest_r  <= dest_mem_r[head_r];
        end else begin
            wb_we_r    <= 1'b0;
        end
    end

    // Busy mask: every valid queued destination plus the one being written now
    always_comb begin
        logic [PTR_W-1:0] slot;
        busy_s = 32'h0;
        slot   = head_r;
        for (int i = 0; i < DEPTH; i++) begin
            slot = head_r + PTR_W'(i);
            if (CNT_W'(i) < count_r) begin
                busy_s = busy_s | (32'h1 << dest_mem_r[slot]);
            end else begin
                busy_s = busy_s;
            end
        end
        if (wb_we_r) begin
            busy_s = busy_s | (32'h1 << wb_dest_r);
        end else begin
            busy_s = busy_s;
        end
        // non-writing entries carry index 0; $0 is never busy
        busy_s[0] = 1'b0;
    end

    assign in_ready             = ~full_s;
    assign occupancy            = count_r;
    assign busy_mask            = busy_s;
    assign wb_write_enable      = wb_we_r;
    assign wb_instruction_check = wb_check_r;
    assign wb_instruction       = wb_instr_r;
    assign wb_data              = wb_data_r;

endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instruction;
    logic [31:0]      in_result;
    logic             wb_stall;
    logic             flush;
    logic             wb_write_enable;
    logic             wb_instruction_check;
    logic [31:0]      wb_instruction;
    logic [31:0]      wb_data;
    logic [31:0]      busy_mask;
    logic [CNT_W-1:0] occupancy;

    regfile_writeback #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .in_instruction       (in_instruction),
        .in_result            (in_result),
        .wb_stall             (wb_stall),
        .flush                (flush),
        .wb_write_enable      (wb_write_enable),
        .wb_instruction_check (wb_instruction_check),
        .wb_instruction       (wb_instruction),
        .wb_data              (wb_data),
        .busy_mask            (busy_mask),
        .occupancy            (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] result;
    } entry_t;

    entry_t mq[$];     // model of the buffered results, oldest first
    entry_t exp_q[$];  // scoreboard: writes expected on the register file port
    bit     iss_we;    // model: a write pulse is on the port this cycle
    int     iss_dest;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual %h required %h", name, act, req);
    endtask

    // Register that a result writes to (0 = nothing written)
    function automatic int dest_of(input logic [31:0] ins);
        int op;
        op = int'(ins[31:26]);
        if (op == 0) return (ins[5:0] == 6'h08) ? 0 : int'(ins[15:11]);
        if (op inside {8, 9, 10, 12, 13, 15, 35}) return int'(ins[20:16]);
        return 0;
    endfunction

    function automatic logic [31:0] model_busy();
        logic [31:0] m;
        m = 32'h0;
        foreach (mq[i]) if (dest_of(mq[i].instr) != 0) m[dest_of(mq[i].instr)] = 1'b1;
        if (iss_we) m[iss_dest] = 1'b1;
        return m;
    endfunction

    // Advance one clock, applying the behavioural rules to the model
    task automatic step();
        bit do_push, do_pop;
        entry_t e;
        do_push = rst_n && in_valid && (mq.size() < DEPTH) && !flush;
        do_pop  = rst_n && (mq.size() > 0) && !wb_stall && !flush;
        e.instr  = in_instruction;
        e.result = in_result;
        @(posedge clk);
        iss_we = 1'b0;
        if (rst_n && flush) begin
            mq.delete();
        end else begin
            if (do_pop) begin
                entry_t h;
                h = mq.pop_front();
                if (dest_of(h.instr) != 0) begin
                    iss_we   = 1'b1;
                    iss_dest = dest_of(h.instr);
                    exp_q.push_back(h);
                end
            end
            if (do_push) mq.push_back(e);
        end
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] res, input bit st, input bit fl);
        in_valid       = v;
        in_instruction = ins;
        in_result      = res;
        wb_stall       = st;
        flush          = fl;
    endtask

    function automatic logic [31:0] rand_instr();
        int ops[11] = '{0, 8, 9, 10, 12, 13, 15, 35, 43, 4, 2};
        int fns[3]  = '{32, 8, 34};
        logic [31:0] r;
        r = $urandom;
        r[31:26] = 6'(ops[$urandom_range(0, 10)]);
        if (r[31:26] == 6'h00) r[5:0] = 6'(fns[$urandom_range(0, 2)]);
        return r;
    endfunction

    // Monitor: compares port behaviour against the model and pops the scoreboard on each pulse
    always @(negedge clk) begin
        check(wb_write_enable == iss_we, "wb_write_enable", 32'(wb_write_enable), 32'(iss_we));
        check(int'(occupancy) == mq.size(), "occupancy", 32'(occupancy), 32'(mq.size()));
        check(in_ready == (mq.size() < DEPTH), "in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
        check(busy_mask == model_busy(), "busy_mask", busy_mask, model_busy());
        if (wb_write_enable) begin
            if (exp_q.size() == 0) begin
                check(1'b0, "unexpected_pulse", wb_instruction, 32'h0);
            end else begin
                entry_t x;
                x = exp_q.pop_front();
                check(wb_instruction == x.instr, "wb_instruction", wb_instruction, x.instr);
                check(wb_data == x.result, "wb_data", wb_data, x.result);
                check(wb_instruction_check == (x.instr[31:26] != 6'h00), "wb_check",
                      32'(wb_instruction_check), 32'(x.instr[31:26] != 6'h00));
            end
        end
    end

    initial begin
        iss_we = 1'b0;
        iss_dest = 0;
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check(in_ready == 1'b1, "reset_in_ready", 32'(in_ready), 32'h1);
        check(occupancy == 3'd0, "reset_occupancy", 32'(occupancy), 32'h0);
        check(wb_write_enable == 1'b0 && wb_data == 32'h0 && wb_instruction == 32'h0,
              "reset_wb", wb_data | wb_instruction, 32'h0);
        rst_n = 1'b1;
        step();

        // 1: R-type add $3
        drive(1'b1, 32'h00221820, 32'h00001234, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check(busy_mask[3] == 1'b1, "t1_busy_queued", busy_mask, 32'h8);
        step();
        check(wb_write_enable == 1'b1 && wb_data == 32'h1234, "t1_pulse", wb_data, 32'h1234);
        check(busy_mask[3] == 1'b1, "t1_busy_issuing", busy_mask, 32'h8);
        step();
        check(busy_mask == 32'h0, "t1_busy_clear", busy_mask, 32'h0);

        // 2: addi $5, sw, add $0, jr, lw $7
        drive(1'b1, 32'h20050007, 32'h7, 1'b0, 1'b0);          step();
        drive(1'b1, 32'hAC450004, 32'hDEAD, 1'b0, 1'b0);       step();
        drive(1'b1, 32'h00220020, 32'hBEEF, 1'b0, 1'b0);       step();
        drive(1'b1, 32'h03E00008, 32'h1111, 1'b0, 1'b0);       step();
        drive(1'b1, 32'h8C070010, 32'h2222, 1'b0, 1'b0);       step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (3) step();

        // 3: DEPTH+1 pushes while stalled, then release
        for (int i = 1; i <= DEPTH + 1; i++) begin
            drive(1'b1, 32'h20000000 | (32'(i) << 16), 32'h100 + 32'(i), 1'b1, 1'b0);
            step();
        end
        check(occupancy == 3'd4, "t3_occupancy_full", 32'(occupancy), 32'h4);
        check(in_ready == 1'b0, "t3_in_ready_full", 32'(in_ready), 32'h0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (DEPTH + 2) step();

        // 4: push and pop together at occupancy 2
        drive(1'b1, 32'h20080001, 32'hA1, 1'b1, 1'b0); step();
        drive(1'b1, 32'h20090002, 32'hA2, 1'b1, 1'b0); step();
        drive(1'b1, 32'h200A0003, 32'hA3, 1'b0, 1'b0); step();
        check(occupancy == 3'd2, "t4_occupancy_steady", 32'(occupancy), 32'h2);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (4) step();

        // 5: flush with 3 queued and a push in the same cycle
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h200B0000 | (32'(i + 11) << 16), 32'hB0 + 32'(i), 1'b1, 1'b0);
            step();
        end
        drive(1'b1, 32'h20100009, 32'hFF, 1'b0, 1'b1);
        step();
        check(occupancy == 3'd0, "t5_occupancy", 32'(occupancy), 32'h0);
        check(busy_mask == 32'h0, "t5_busy", busy_mask, 32'h0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        check(wb_write_enable == 1'b0, "t5_no_pulse", 32'(wb_write_enable), 32'h0);

        // 6: asynchronous reset mid-burst
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h20110000 | (32'(i + 17) << 16), 32'hC0 + 32'(i), 1'b0, 1'b0);
            step();
        end
        #2;
        rst_n = 1'b0;
        mq.delete();
        exp_q.delete();
        iss_we = 1'b0;
        #1;
        check(wb_write_enable == 1'b0 && occupancy == 3'd0 && busy_mask == 32'h0 && in_ready == 1'b1,
              "t6_async_reset", busy_mask | 32'(occupancy) | 32'(wb_write_enable), 32'h0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (3) step();
        drive(1'b1, 32'h8C140055, 32'h5555, 1'b0, 1'b0); step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (3) step();

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            drive(($urandom % 4) != 0, rand_instr(), $urandom, ($urandom % 4) == 0, ($urandom % 32) == 0);
            step();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (DEPTH + 3) step();
        @(negedge clk);
        #1;
        check(exp_q.size() == 0, "scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
